// File: rtl/seg_disp_pkg.sv
// Shared types, widths and segment constants for the two-digit seven-segment
// seconds counter.
package seg_disp_pkg;

  localparam int SEG_W = 9;  // [8]=digit enable, [7]=DP, [6:0]=g..a
  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic       DIG_ON    = 1'b0;  // digit enable is active-low

  // Active-high segment patterns, bit order g..a, indexed by decimal digit.
  localparam logic [0:9][6:0] SEG_CODES = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Two-digit BCD count value.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd_pair_t;

  localparam bcd_pair_t BCD_ZERO = '{tens: 4'd0, units: 4'd0};

  // Next value of the 00..99 counter, wrapping 99 -> 00.
  function automatic bcd_pair_t bcd_next(input bcd_pair_t cur);
    bcd_pair_t nxt;
    nxt = cur;
    if (cur.units != 4'd9) begin
      nxt.units = cur.units + 4'd1;
    end else begin
      nxt.units = 4'd0;
      nxt.tens  = (cur.tens == 4'd9) ? 4'd0 : cur.tens + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seg_disp_seg_decoder.sv
// BCD digit to seven-segment (g..a, active-high) decoder; non-decimal codes blank.
module seg_decoder
  import seg_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Table lookup; codes 10..15 fall through to blank.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_CODES[0];
      4'd1: seg = SEG_CODES[1];
      4'd2: seg = SEG_CODES[2];
      4'd3: seg = SEG_CODES[3];
      4'd4: seg = SEG_CODES[4];
      4'd5: seg = SEG_CODES[5];
      4'd6: seg = SEG_CODES[6];
      4'd7: seg = SEG_CODES[7];
      4'd8: seg = SEG_CODES[8];
      4'd9: seg = SEG_CODES[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_disp_top.sv
// Two-digit seven-segment seconds counter: clock divider -> BCD 00..99 counter
// -> two segment decoders, plus a status LED toggling on every tick.
// Optional feature macro SEG_DP_BLINK_EN: when defined, the units-digit DP
// (seg_led_2[7]) follows the LED; otherwise both DPs are held at 0.
module seg_disp_top
  import seg_disp_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000  // clk cycles per tick, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             led,
  output logic [SEG_W-1:0] seg_led_1,
  output logic [SEG_W-1:0] seg_led_2
);

  localparam int            DIV_W     = $clog2(TICK_CYCLES);
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_CYCLES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  bcd_pair_t        count;
  logic [6:0]       tens_seg;
  logic [6:0]       units_seg;

  // Tick is high during the last divider cycle, so the count advances on the
  // edge that wraps the divider: first advance TICK_CYCLES edges after reset.
  assign tick = (div_cnt == TICK_LAST);

  // Free-running divider 0..TICK_CYCLES-1; reset restarts it from 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // BCD seconds counter, advancing once per tick and wrapping 99 -> 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= BCD_ZERO;
    end else if (tick) begin
      count <= bcd_next(count);
    end
  end

  // Status LED toggles on every tick, giving a period of 2*TICK_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else if (tick) begin
      led <= ~led;
    end
  end

  seg_decoder u_dec_tens (
    .bcd (count.tens),
    .seg (tens_seg)
  );

  seg_decoder u_dec_units (
    .bcd (count.units),
    .seg (units_seg)
  );

  // Segment buses: decode of registered digits, no added latency. Tens DP is
  // always off; the units DP optionally mirrors the LED.
  assign seg_led_1 = {DIG_ON, 1'b0, tens_seg};
`ifdef SEG_DP_BLINK_EN
  assign seg_led_2 = {DIG_ON, led, units_seg};
`else
  assign seg_led_2 = {DIG_ON, 1'b0, units_seg};
`endif

endmodule

// File: tb/tb_seg_disp_top.sv
// Self-checking bench for seg_disp_top with TICK_CYCLES=10: table-driven
// display/LED vectors along a continuous run, plus hand-written sequences for
// the 99->00 wrap and an asynchronous mid-count reset.
module tb_seg_disp_top;

  localparam int TICK = 10;

  logic       clk;
  logic       rst;
  logic       led;
  logic [8:0] seg_led_1;
  logic [8:0] seg_led_2;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  seg_disp_top #(.TICK_CYCLES(TICK)) dut (
    .clk       (clk),
    .rst       (rst),
    .led       (led),
    .seg_led_1 (seg_led_1),
    .seg_led_2 (seg_led_2)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 9'h%03h, expected 9'h%03h", name, act, exp);
    end
  endtask

  // Compare all outputs against a two-digit expectation; units DP follows
  // the expected LED only when the blink feature is built in.
  task automatic check_disp(input string name, input logic exp_led,
                            input logic [8:0] exp1, input logic [8:0] exp2);
    logic [8:0] e2;
    e2 = exp2;
`ifdef SEG_DP_BLINK_EN
    e2[7] = exp_led;
`endif
    check({name, " led"},  {8'd0, led}, {8'd0, exp_led});
    check({name, " seg1"}, seg_led_1, exp1);
    check({name, " seg2"}, seg_led_2, e2);
  endtask

  // Advance n rising edges, then sample on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Fixed bits every cycle: digit enables low, tens DP low, units DP per build.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("dig_en/tens_dp", {6'd0, seg_led_1[8], seg_led_1[7], seg_led_2[8]}, 9'd0);
`ifdef SEG_DP_BLINK_EN
      check("units_dp", {8'd0, seg_led_2[7]}, {8'd0, led});
`else
      check("units_dp", {8'd0, seg_led_2[7]}, 9'd0);
`endif
    end
  end

  typedef struct {
    string      name;
    int         cycles;  // rising edges to run before sampling
    logic       led;
    logic [8:0] seg1;
    logic [8:0] seg2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Cumulative edges after release: 0,9,10,20,90,100,370,450,680 -> values
    // 00,00,01,02,09,10,37,45,68; led = parity of the tick count.
    vecs[0] = '{"reset_state", 0,   1'b0, 9'h03F, 9'h03F};
    vecs[1] = '{"pre_tick",    9,   1'b0, 9'h03F, 9'h03F};
    vecs[2] = '{"first_tick",  1,   1'b1, 9'h03F, 9'h006};
    vecs[3] = '{"val_02",      10,  1'b0, 9'h03F, 9'h05B};
    vecs[4] = '{"val_09",      70,  1'b1, 9'h03F, 9'h06F};
    vecs[5] = '{"carry_10",    10,  1'b0, 9'h006, 9'h03F};
    vecs[6] = '{"val_37",      270, 1'b1, 9'h04F, 9'h007};
    vecs[7] = '{"val_45",      80,  1'b1, 9'h066, 9'h06D};
    vecs[8] = '{"val_68",      230, 1'b0, 9'h07D, 9'h07F};

    rst = 1'b1;
    repeat (5) @(negedge clk);  // 200 ns of reset
    check_disp("in_reset", 1'b0, 9'h03F, 9'h03F);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].cycles > 0) step(vecs[i].cycles);
      check_disp(vecs[i].name, vecs[i].led, vecs[i].seg1, vecs[i].seg2);
    end

    // 99 -> 00 wrap: 990 edges gives 99 (odd ticks), 1000 gives 00.
    step(310);
    check_disp("val_99", 1'b1, 9'h06F, 9'h06F);
    step(9);
    check_disp("hold_99", 1'b1, 9'h06F, 9'h06F);
    step(1);
    check_disp("wrap_00", 1'b0, 9'h03F, 9'h03F);

    // Reach "37" with the divider at 5, then reset between clock edges.
    step(375);
    check_disp("pre_rst_37", 1'b1, 9'h04F, 9'h007);
    #5 rst = 1'b1;
    #1 check_disp("async_rst", 1'b0, 9'h03F, 9'h03F);
    step(2);
    check_disp("rst_held", 1'b0, 9'h03F, 9'h03F);
    rst = 1'b0;
    step(9);
    check_disp("post_rst_9", 1'b0, 9'h03F, 9'h03F);
    step(1);
    check_disp("post_rst_10", 1'b1, 9'h03F, 9'h006);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
